tx_control: RTL and testbench

// - Return path of the UART calculator: on a one-cycle trigger (tx_signal from the RX sequencer),

---
 rtl/tx_control_pkg.sv | 34 +++
 rtl/tx_control.sv | 151 +++++++++++++++
 tb/tb_tx_control.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_control_pkg.sv
// rtl/tx_control_pkg.sv - shared constants and state encoding for the calculator return path
//
// Purpose
//   Definitions shared by tx_control and rx_control: FSM state codes, the default frame
//   geometry, the acknowledge timeout, and the on-wire byte order of a result frame.
//   rx_control assembles operands in the same order that tx_control sends results, so
//   both sides import LSB_FIRST from here rather than hard-coding it.

package tx_control_pkg;

   // Frame geometry and handshake defaults
   localparam int N_BYTES_DEFAULT     = 2;
   localparam int ACK_TIMEOUT_DEFAULT = 16;

   // Byte order on the serial link: 1 = least significant byte goes out first
   localparam bit LSB_FIRST = 1'b1;

   // FSM state codes (kept as plain 3-bit constants so legacy code can compare against them)
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_LOAD      = 3'd1;
   localparam state_t ST_START     = 3'd2;
   localparam state_t ST_WAIT_ACK  = 3'd3;
   localparam state_t ST_WAIT_DONE = 3'd4;
   localparam state_t ST_NEXT      = 3'd5;
   localparam state_t ST_FINISH    = 3'd6;

   // Width of a byte index for an n-byte frame; never narrower than one bit
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tx_control.sv
// rtl/tx_control.sv - streams a latched ALU result to UART_tx one byte at a time
//
// Purpose
//   On a one-cycle trigger from the RX sequencer, captures the ALU result into a shadow
//   register and hands it to the UART transmitter byte by byte (order from LSB_FIRST).
//   Each byte is offered with a one-cycle tx_start pulse; the block then follows the
//   transmitter's busy flag until the byte has gone out. If the transmitter never raises
//   busy, the byte is considered taken after ACK_TIMEOUT cycles so a missing or stuck
//   transmitter cannot hang the calculator.
//
// Ports
//   clk        in   1           system clock
//   reset      in   1           asynchronous, active-low reset (release is expected to be
//                               synchronised to clk upstream)
//   tx_signal  in   1           frame request, one-cycle pulse
//   result     in   8*N_BYTES   value to send; sampled only when a request is accepted
//   tx_busy    in   1           UART_tx is shifting a byte out
//   tx_start   out  1           one-cycle pulse: UART_tx loads tx_data
//   tx_data    out  8           byte for UART_tx; only updated while preparing a byte
//   busy       out  1           frame in progress (cycle after accept up to done)
//   done       out  1           one-cycle pulse once the last byte has completed
//   overrun    out  1           sticky: a request arrived while a frame was in progress

module tx_control
   import tx_control_pkg::*;
#(
   parameter int N_BYTES     = N_BYTES_DEFAULT,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tx_signal,
   input  logic [8*N_BYTES-1:0]   result,
   input  logic                   tx_busy,
   output logic                   tx_start,
   output logic [7:0]             tx_data,
   output logic                   busy,
   output logic                   done,
   output logic                   overrun
);

   localparam int IDX_W = idx_width(N_BYTES);
   localparam int CNT_W = $clog2(ACK_TIMEOUT);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_TIMEOUT - 1);

   state_t               state_q;
   logic [IDX_W-1:0]     idx_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [8*N_BYTES-1:0] shadow_q;

   logic [IDX_W-1:0]     byte_pos;
   logic [7:0]           cur_byte;

   // Byte mux: idx_q counts bytes already handed over; byte_pos maps that onto the
   // position inside the shadow register according to the link byte order.
   always_comb begin
      byte_pos = LSB_FIRST ? idx_q : (LAST_IDX - idx_q);
      cur_byte = shadow_q[{byte_pos, 3'b000} +: 8];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         busy     <= 1'b0;
         done     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         // Pulse outputs default low; the states below raise them for exactly one cycle.
         tx_start <= 1'b0;
         done     <= 1'b0;

         // Any request outside IDLE is dropped, including one landing on the FINISH
         // cycle; the frame in flight carries on untouched.
         if (tx_signal && (state_q != ST_IDLE)) begin
            overrun <= 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (tx_signal) begin
                  shadow_q <= result;
                  idx_q    <= '0;
                  busy     <= 1'b1;
                  state_q  <= ST_LOAD;
               end
            end

            // Present the byte, but do not offer it while the transmitter is still busy
            // with something else (e.g. a previous frame's last byte).
            ST_LOAD: begin
               tx_data <= cur_byte;
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  state_q  <= ST_START;
               end
            end

            // tx_start is high during this state; arm the acknowledge timeout.
            ST_START: begin
               cnt_q   <= CNT_LOAD;
               state_q <= ST_WAIT_ACK;
            end

            // A transmitter that never answers is treated as having taken the byte.
            ST_WAIT_ACK: begin
               if (tx_busy) begin
                  state_q <= ST_WAIT_DONE;
               end else if (cnt_q == '0) begin
                  state_q <= ST_NEXT;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  state_q <= ST_NEXT;
               end
            end

            ST_NEXT: begin
               if (idx_q == LAST_IDX) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= ST_FINISH;
               end else begin
                  idx_q   <= idx_q + 1'b1;
                  state_q <= ST_LOAD;
               end
            end

            // done is high during this state; one cycle later requests are accepted again.
            ST_FINISH: begin
               state_q <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_control.sv
// tb/tb_tx_control.sv - self-checking bench for tx_control

module tb_tx_control;

   localparam int N  = 2;
   localparam int AT = 16;

   logic        clk       = 1'b0;
   logic        reset     = 1'b0;
   logic        tx_signal = 1'b0;
   logic [15:0] result    = 16'h0000;
   logic        tx_busy   = 1'b0;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        busy;
   logic        done;
   logic        overrun;

   tx_control #(.N_BYTES(N), .ACK_TIMEOUT(AT)) dut (
      .clk       (clk),
      .reset     (reset),
      .tx_signal (tx_signal),
      .result    (result),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .busy      (busy),
      .done      (done),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Transmitter environment: answers a tx_start with busy after env_r cycles for
   // env_len cycles, or never when env_timeout is set; hold window forces busy high.
   bit env_timeout = 1'b0;
   int env_r       = 1;
   int env_len     = 10;
   int hold_from   = -1;
   int hold_to     = -2;
   bit uart_valid  = 1'b0;
   int uart_s      = 0;

   // Frame-level reference: event cycles computed from the accept cycle and the
   // environment's response times.
   bit          m_valid = 1'b0;
   int          m_t     = 0;
   int          m_s0    = 0;
   int          m_step  = 1;
   int          m_F     = 0;
   logic [15:0] m_val   = 16'h0000;
   bit          m_ovr   = 1'b0;
   logic [7:0]  m_data  = 8'h00;

   int         start_log[$];
   logic [7:0] data_log[$];
   int         done_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic env_busy(input int n);
      return ((n >= hold_from) && (n <= hold_to)) ||
             (!env_timeout && uart_valid && (n >= uart_s + env_r) && (n < uart_s + env_r + env_len));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      tx_signal = 1'b0;
      tx_busy   = env_busy(cyc);
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic trigger(output int t);
      tick();
      tx_signal = 1'b1;
      t = cyc;
   endtask

   task automatic clear_logs();
      start_log.delete();
      data_log.delete();
      done_log.delete();
   endtask

   task automatic frame_chk(input string nm, input int t, input int s0, input int s1,
                            input logic [7:0] d0, input logic [7:0] d1, input int dn);
      chk({nm, " starts"}, start_log.size(), 2);
      chk({nm, " dones"}, done_log.size(), 1);
      if (start_log.size() == 2) begin
         chk({nm, " start0"}, start_log[0] - t, s0);
         chk({nm, " start1"}, start_log[1] - t, s1);
         chk({nm, " byte0"}, data_log[0], d0);
         chk({nm, " byte1"}, data_log[1], d1);
      end
      if (done_log.size() == 1) chk({nm, " done"}, done_log[0] - t, dn);
   endtask

   // Per-cycle compare against the reference
   always @(negedge clk) begin
      logic e_start, e_busy, e_done;
      int   k;
      e_start = 1'b0;
      e_busy  = 1'b0;
      e_done  = 1'b0;
      if (!reset) begin
         m_valid    = 1'b0;
         m_ovr      = 1'b0;
         m_data     = 8'h00;
         uart_valid = 1'b0;
      end else if (m_valid) begin
         e_busy = (cyc >= m_t + 1) && (cyc < m_F);
         e_done = (cyc == m_F);
         if ((cyc >= m_s0) && ((cyc - m_s0) % m_step == 0) && ((cyc - m_s0) / m_step < N))
            e_start = 1'b1;
         if (cyc >= m_t + 2) begin
            k = (cyc < m_s0) ? 0 : (cyc - m_s0) / m_step;
            if (k > N - 1) k = N - 1;
            m_data = m_val[8*k +: 8];
         end
      end
      if (cyc > 0) begin
         chk("tx_start", tx_start, e_start);
         chk("tx_data", tx_data, m_data);
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("overrun", overrun, m_ovr);
      end
      if (tx_start) begin
         start_log.push_back(cyc);
         data_log.push_back(tx_data);
         uart_s     = cyc;
         uart_valid = reset;
      end
      if (done) done_log.push_back(cyc);
      if (reset && tx_signal) begin
         if (m_valid && (cyc <= m_F)) begin
            m_ovr = 1'b1;
         end else begin
            m_valid = 1'b1;
            m_t     = cyc;
            m_val   = result;
            m_s0    = ((hold_from <= cyc + 1) && (hold_to >= cyc + 1)) ? hold_to + 2 : cyc + 2;
            m_step  = env_timeout ? AT + 3 : env_r + env_len + 3;
            m_F     = m_s0 + N * m_step - 1;
         end
      end
   end

   initial begin
      int t;
      int t2;

      // Reset held for a few cycles
      run(3);
      tick();
      reset = 1'b1;
      run(2);
      chk("reset tx_data", tx_data, 8'h00);
      chk("reset overrun", overrun, 1'b0);

      // Basic frame
      clear_logs();
      result = 16'hA55A;
      trigger(t);
      run(40);
      frame_chk("basic", t, 2, 16, 8'h5A, 8'hA5, 29);

      // Hold-off: transmitter busy for 20 cycles from the trigger
      clear_logs();
      result    = 16'h3C96;
      hold_from = cyc + 1;
      hold_to   = cyc + 20;
      trigger(t);
      run(60);
      frame_chk("holdoff", t, 21, 35, 8'h96, 8'h3C, 48);
      hold_from = -1;
      hold_to   = -2;

      // Timeout: transmitter never answers
      clear_logs();
      env_timeout = 1'b1;
      result      = 16'h0102;
      trigger(t);
      run(50);
      frame_chk("timeout", t, 2, 21, 8'h02, 8'h01, 39);
      chk("timeout overrun", overrun, 1'b0);
      env_timeout = 1'b0;

      // Result changes one cycle after the trigger
      clear_logs();
      result = 16'h1234;
      trigger(t);
      tick();
      result = 16'hFFFF;
      run(40);
      frame_chk("hazard", t, 2, 16, 8'h34, 8'h12, 29);

      // Second request five cycles into a frame
      clear_logs();
      result = 16'hC0DE;
      trigger(t);
      run(4);
      tick();
      tx_signal = 1'b1;
      run(45);
      frame_chk("overrun", t, 2, 16, 8'hDE, 8'hC0, 29);
      chk("overrun sticky", overrun, 1'b1);

      // Reset during WAIT_DONE of byte 0
      result = 16'h5555;
      trigger(t);
      run(6);
      tick();
      chk("pre-reset busy", busy, 1'b1);
      reset = 1'b0;
      #1;
      chk("mid reset busy", busy, 1'b0);
      chk("mid reset tx_data", tx_data, 8'h00);
      chk("mid reset overrun", overrun, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      run(2);
      clear_logs();
      result = 16'h00C3;
      trigger(t);
      run(40);
      frame_chk("after reset", t, 2, 16, 8'hC3, 8'h00, 29);
      chk("after reset overrun", overrun, 1'b0);

      // Request on the done cycle is dropped, the one right after is accepted
      clear_logs();
      result = 16'h7E81;
      trigger(t);
      run(28);
      tick();
      tx_signal = 1'b1;
      tick();
      result    = 16'h1FF8;
      tx_signal = 1'b1;
      t2        = cyc;
      run(40);
      chk("collision t2", t2 - t, 30);
      chk("collision starts", start_log.size(), 4);
      chk("collision dones", done_log.size(), 2);
      if (start_log.size() == 4) begin
         chk("collision s2", start_log[2] - t, 32);
         chk("collision s3", start_log[3] - t, 46);
         chk("collision b0", data_log[0], 8'h81);
         chk("collision b1", data_log[1], 8'h7E);
         chk("collision b2", data_log[2], 8'hF8);
         chk("collision b3", data_log[3], 8'h1F);
      end
      if (done_log.size() == 2) begin
         chk("collision d0", done_log[0] - t, 29);
         chk("collision d1", done_log[1] - t, 59);
      end
      chk("collision overrun", overrun, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
